vector_exec_unit: RTL

VECTOR_EXEC_UNIT -- requirements
Module: vector_exec_unit

---
 rtl/vector_exec_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/vector_exec_unit.sv
// Multi-lane vector execution unit: LOAD/STORE against external vector memory and VADD/VMUL with widening writeback.
// Optional macro VP_SAT_EN: VADD saturates each lane into rd and leaves rd+1 untouched.
module vector_exec_unit #(
    parameter int LANES  = 16,
    parameter int ELEM_W = 32,
    parameter int NREG   = 4,
    parameter int AW     = 9,
    localparam int RW    = $clog2(NREG),
    localparam int VW    = LANES * ELEM_W,
    localparam int IW    = 2 + 3 * RW + AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [IW-1:0] instr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [VW-1:0] mem_wdata,
    input  logic [VW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          done,
    input  logic [RW-1:0] dbg_sel,
    output logic [VW-1:0] dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_EXEC, S_WB} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_VADD  = 2'b10;
    localparam logic [1:0] OP_VMUL  = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_op;
    logic [RW-1:0]       r_rd;
    logic [VW-1:0]       r_opa;
    logic [VW-1:0]       r_opb;
    logic [VW-1:0]       r_res_lo;
    logic [VW-1:0]       r_res_hi;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [AW-1:0]       r_mem_addr;
    logic [VW-1:0]       r_mem_wdata;
    logic [VW-1:0]       r_regs [NREG];

    logic [1:0]          w_op;
    logic [RW-1:0]       w_rd;
    logic [RW-1:0]       w_rs1;
    logic [RW-1:0]       w_rs2;
    logic [AW-1:0]       w_addr;
    logic                w_ready;
    logic                w_accept;
    logic                w_mem_done;
    logic                w_hi_we;
    logic [VW-1:0]       w_lo;
    logic [VW-1:0]       w_hi;
    logic [2*ELEM_W-1:0] w_full;

    assign w_op   = instr[IW-1 -: 2];
    assign w_rd   = instr[AW+3*RW-1 -: RW];
    assign w_rs1  = instr[AW+2*RW-1 -: RW];
    assign w_rs2  = instr[AW+RW-1 -: RW];
    assign w_addr = instr[AW-1:0];

    // Ready is gated by reset so it reads 0 while reset is held low.
    assign w_ready    = (r_state == S_IDLE) && reset;
    assign w_accept   = w_ready && instr_valid;
    assign w_mem_done = (r_state == S_MEM) && r_mem_req && mem_ack;

`ifdef VP_SAT_EN
    assign w_hi_we = (r_op != OP_VADD);
`else
    assign w_hi_we = 1'b1;
`endif

    assign instr_ready = w_ready;
    assign done        = w_mem_done || (r_state == S_WB);
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign dbg_data    = r_regs[dbg_sel];

    // Per-lane widening add/multiply on the operands captured at accept.
    always_comb begin
        w_lo   = '0;
        w_hi   = '0;
        w_full = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_op == OP_VADD) begin
                w_full = {{ELEM_W{1'b0}}, r_opa[l*ELEM_W +: ELEM_W]}
                       + {{ELEM_W{1'b0}}, r_opb[l*ELEM_W +: ELEM_W]};
            end else begin
                w_full = {{ELEM_W{1'b0}}, r_opa[l*ELEM_W +: ELEM_W]}
                       * {{ELEM_W{1'b0}}, r_opb[l*ELEM_W +: ELEM_W]};
            end
`ifdef VP_SAT_EN
            w_lo[l*ELEM_W +: ELEM_W] = ((r_op == OP_VADD) && w_full[ELEM_W])
                                     ? {ELEM_W{1'b1}} : w_full[ELEM_W-1:0];
`else
            w_lo[l*ELEM_W +: ELEM_W] = w_full[ELEM_W-1:0];
`endif
            w_hi[l*ELEM_W +: ELEM_W] = w_full[2*ELEM_W-1:ELEM_W];
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((w_op == OP_LOAD) || (w_op == OP_STORE)) begin
                        w_next = S_MEM;
                    end else begin
                        w_next = S_EXEC;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MEM: begin
                if (w_mem_done) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction capture, memory handshake and result staging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op        <= 2'b00;
            r_rd        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_res_lo    <= '0;
            r_res_hi    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_rd  <= w_rd;
            r_opa <= r_regs[w_rs1];
            r_opb <= r_regs[w_rs2];
            if ((w_op == OP_LOAD) || (w_op == OP_STORE)) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= (w_op == OP_STORE);
                r_mem_addr <= w_addr;
                if (w_op == OP_STORE) begin
                    r_mem_wdata <= r_regs[w_rs1];
                end
            end
        end else if (w_mem_done) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_res_lo <= w_lo;
            r_res_hi <= w_hi;
        end
    end

    // Vector register file; the high half wraps to register 0 past the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_mem_done && !r_mem_we) begin
            r_regs[r_rd] <= mem_rdata;
        end else if (r_state == S_WB) begin
            r_regs[r_rd] <= r_res_lo;
            if (w_hi_we) begin
                r_regs[r_rd + RW'(1)] <= r_res_hi;
            end
        end
    end

endmodule
